// File: rtl/as_uart_pkg.sv
// as_uart_pkg: shared FSM state encoding and frame constants for the UART transceiver
package as_uart_pkg;
  localparam int FRAME_DATA_BITS = 8;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
endpackage

// File: rtl/as_uart_bit_timer.sv
// as_uart_bit_timer: loadable 16-bit down-counter; expired goes high the interval-th cycle after a load
module as_uart_bit_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] interval,
  output logic        expired
);
  logic [15:0] cnt;
  // count down to zero and hold there until the next load
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= interval - 16'd1;
    else if (cnt != '0) cnt <= cnt - 16'd1;
  assign expired = cnt == '0;
endmodule

// File: rtl/as_uart.sv
// as_uart: 8N1 UART byte transceiver for the AS byte interface; even parity when AS_UART_PARITY_EN is defined
module as_uart
  import as_uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic       serial_out,
  output logic [7:0] as_data_o,
  output logic       as_dstrb_o,
  input  logic [7:0] as_data_i,
  input  logic       as_dstrb_i,
  output logic       as_busy_o,
  output logic       rx_frame_err_o
);
  localparam logic [15:0] BIT_LEN  = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_LEN = 16'(BAUD_DIV / 2);
  localparam logic [2:0]  LAST_BIT = 3'(FRAME_DATA_BITS - 1);
`ifdef AS_UART_PARITY_EN
  localparam uart_state_t RX_AFTER_DATA = S_PARITY;
`else
  localparam uart_state_t RX_AFTER_DATA = S_STOP;
`endif
  logic        rx_s1, rx_s2, rx_prev;
  uart_state_t rx_state, tx_state;
  logic [7:0]  rx_sh, tx_sh;
  logic [2:0]  rx_cnt, tx_cnt;
  logic        rx_load, rx_exp, tx_load, tx_exp, rx_par_ok;
  logic [15:0] rx_interval;
`ifdef AS_UART_PARITY_EN
  logic        rx_par, tx_par;
  assign rx_par_ok = (^rx_sh) == rx_par;
`else
  assign rx_par_ok = 1'b1;
`endif
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_s1, rx_s2, rx_prev} <= 3'b111;
    else {rx_s1, rx_s2, rx_prev} <= {serial_in, rx_s1, rx_s2};
  // timers reload on every expiry; RX start detection arms a half-bit delay to land mid-bit
  always_comb begin
    rx_load     = (rx_state == S_IDLE) ? (rx_prev && !rx_s2) : rx_exp;
    rx_interval = (rx_state == S_IDLE) ? HALF_LEN : BIT_LEN;
    tx_load     = (tx_state == S_IDLE) ? (as_dstrb_i && !as_busy_o) : tx_exp;
  end
  as_uart_bit_timer rx_timer (.clk(clk), .reset(reset), .load(rx_load), .interval(rx_interval), .expired(rx_exp));
  as_uart_bit_timer tx_timer (.clk(clk), .reset(reset), .load(tx_load), .interval(BIT_LEN), .expired(tx_exp));
  // receive FSM: mid-bit sampling, single-cycle strobe or error at the stop bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_state       <= S_IDLE;
      rx_sh          <= '0;
      rx_cnt         <= '0;
      as_data_o      <= '0;
      as_dstrb_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
`ifdef AS_UART_PARITY_EN
      rx_par         <= 1'b0;
`endif
    end else begin
      as_dstrb_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (rx_state)
        S_IDLE:
          if (rx_prev && !rx_s2) rx_state <= S_START;
        S_START:
          if (rx_exp) begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_cnt   <= '0;
          end
        S_DATA:
          if (rx_exp) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == LAST_BIT) rx_state <= RX_AFTER_DATA;
          end
`ifdef AS_UART_PARITY_EN
        S_PARITY:
          if (rx_exp) begin
            rx_par   <= rx_s2;
            rx_state <= S_STOP;
          end
`endif
        S_STOP:
          if (rx_exp) begin
            rx_state <= S_IDLE;
            if (rx_s2 && rx_par_ok) begin
              as_data_o  <= rx_sh;
              as_dstrb_o <= 1'b1;
            end else rx_frame_err_o <= 1'b1;
          end
        default: rx_state <= S_IDLE;
      endcase
    end
  // transmit FSM: one BAUD_DIV-long bit per timer expiry, busy from accept until stop ends
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state   <= S_IDLE;
      tx_sh      <= '0;
      tx_cnt     <= '0;
      serial_out <= 1'b1;
      as_busy_o  <= 1'b0;
`ifdef AS_UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      case (tx_state)
        S_IDLE:
          if (as_dstrb_i && !as_busy_o) begin
            tx_sh      <= as_data_i;
            serial_out <= 1'b0;
            as_busy_o  <= 1'b1;
            tx_state   <= S_START;
`ifdef AS_UART_PARITY_EN
            tx_par     <= ^as_data_i;
`endif
          end
        S_START:
          if (tx_exp) begin
            serial_out <= tx_sh[0];
            tx_sh      <= {1'b0, tx_sh[7:1]};
            tx_cnt     <= '0;
            tx_state   <= S_DATA;
          end
        S_DATA:
          if (tx_exp) begin
            if (tx_cnt == LAST_BIT) begin
`ifdef AS_UART_PARITY_EN
              serial_out <= tx_par;
              tx_state   <= S_PARITY;
`else
              serial_out <= 1'b1;
              tx_state   <= S_STOP;
`endif
            end else begin
              serial_out <= tx_sh[0];
              tx_sh      <= {1'b0, tx_sh[7:1]};
              tx_cnt     <= tx_cnt + 3'd1;
            end
          end
`ifdef AS_UART_PARITY_EN
        S_PARITY:
          if (tx_exp) begin
            serial_out <= 1'b1;
            tx_state   <= S_STOP;
          end
`endif
        S_STOP:
          if (tx_exp) begin
            as_busy_o <= 1'b0;
            tx_state  <= S_IDLE;
          end
        default: tx_state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/as_uart.md
# as_uart

Serial byte transceiver directly upstream of the AS-to-Wishbone bridge: deserialises 8N1 UART frames from the host into single-cycle byte strobes on the AS byte interface, and serialises response bytes from the bridge back onto the serial line with a busy handshake. It is the only block between the board's debug serial pins and the bridge.

## Interface
- `BAUD_DIV`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range 4 to 65535.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `serial_in` in 1: UART receive line, asynchronous to `clk`, idle high.
- `serial_out` out 1: UART transmit line, idle high.
- `as_data_o` out 8: received byte, valid while `as_dstrb_o` is high.
- `as_dstrb_o` out 1: one-cycle pulse per good received byte.
- `as_data_i` in 8: byte to transmit, sampled when `as_dstrb_i` is high.
- `as_dstrb_i` in 1: transmit request strobe.
- `as_busy_o` out 1: transmitter occupied; strobes while high are dropped.
- `rx_frame_err_o` out 1: one-cycle pulse on a bad stop bit, or a parity mismatch when parity is enabled.

## Operation
- Reset values: `serial_out`=1, `as_busy_o`=0, `as_dstrb_o`=0, `rx_frame_err_o`=0, `as_data_o`=8'h00. Both FSMs return to IDLE.
- Reset mid-frame aborts the frame immediately. The partial byte is discarded, and no strobe or error is produced.
- `serial_in` passes through a 2-flop synchroniser (reset to 1) before any use.
- RX FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: on a synchronised 1→0 edge, load the bit timer with `BAUD_DIV/2` (integer division) and go to START.
  - START: at timer expiry, if the line is still 0, load `BAUD_DIV` and go to DATA. Otherwise return to IDLE (glitch reject).
  - DATA: sample 8 bits LSB-first, one per `BAUD_DIV` cycles, into the shift register. Then go to PARITY if enabled, else STOP.
  - STOP: sample at mid-bit. If the line is 1 and parity is OK, load `as_data_o` and pulse `as_dstrb_o`. Otherwise pulse `rx_frame_err_o` and do not strobe. Return to IDLE in the same cycle; a new start edge is accepted from the next cycle.
- TX FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: on `as_dstrb_i` with `as_busy_o`=0, latch `as_data_i` and go to START.
  - Each TX bit lasts exactly `BAUD_DIV` cycles. The order is start (0), 8 data bits LSB-first, then optional parity, then stop (1).
  - At the end of STOP, return to IDLE and drop `as_busy_o`.
  - `as_dstrb_i` while busy is ignored, with no queueing.
- RX and TX are fully independent. Simultaneous RX strobe and TX start is legal.
- Bit timer is a 16-bit down-counter, where expiry means the count is 0. Width is fixed by `BAUD_DIV` ≤ 65535.

## Timing
- TX start: `as_dstrb_i` is sampled at cycle N. At N+1, `as_busy_o`=1 and `serial_out`=0.
  - This satisfies the bridge, which re-checks busy no earlier than two cycles after its strobe.
- `as_busy_o` deasserts at N+1+10·`BAUD_DIV` (11· with parity). A new strobe is accepted in that same cycle.
- RX latency: the strobe fires 2 (synchroniser) + `BAUD_DIV/2` + 9·`BAUD_DIV` (10· with parity) + 1 cycles after the start-bit falling edge at the pin.
- `as_dstrb_o` and `rx_frame_err_o` are never high together and never longer than one cycle.

## Configuration
- `AS_UART_PARITY_EN` defined: an even-parity bit is inserted after the data on TX and checked on RX. The PARITY states are used. A mismatch gives `rx_frame_err_o` and no strobe, even if the stop bit is good.
- `AS_UART_PARITY_EN` undefined: frames are 8N1. The PARITY states are compiled out and never entered.

## Structure
- Package `as_uart_pkg`: FSM state encodings (shared by RX and TX) and the `FRAME_DATA_BITS`=8 constant.
- Sub-module `as_uart_bit_timer`: a loadable 16-bit down-counter with an expiry flag, instantiated once each in RX and TX.
- RX, TX and the synchroniser live in the top module.

## Test plan
All scenarios use `BAUD_DIV`=16.
1. Reset mid-TX while bit 3 is on the line → `serial_out`=1 and `as_busy_o`=0 immediately. A strobe of 8'h00 ten cycles after reset releases is transmitted normally.
2. TX strobe of 8'hA5 → `as_busy_o` high at N+1. `serial_out` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. Busy falls at N+161. A second strobe at N+5 is ignored.
3. Host sends 8'h02 then 8'h10 back-to-back, with one stop bit each → exactly two `as_dstrb_o` pulses carrying 02 then 10, and no `rx_frame_err_o`.
4. `serial_in` low for 4 cycles then high → no strobe, no error, FSM back in IDLE. A following valid 8'h01 frame is received correctly.
5. Frame 8'h3C sent with its stop bit driven 0 → one `rx_frame_err_o` pulse, no `as_dstrb_o`.
6. With `AS_UART_PARITY_EN` defined: 8'h07 sent with parity bit 0 → error pulse and no strobe. The same byte with parity 1 → strobe carrying 07.
